// File: rtl/jtframe_romrq_arb.sv
// jtframe_romrq_arb: N-slot cached ROM request arbiter in front of a 32-bit SDRAM read port
module jtframe_romrq_arb #(
    parameter int                  SLOTS     = 4,
    parameter int                  AW        = 18,
    parameter logic [SLOTS-1:0]    DW16      = '0,
    parameter int                  RR        = 1,
    parameter logic [SLOTS*22-1:0] OFFSETS   = '0,
    parameter int                  READY_DLY = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS*16-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    input  logic                  downloading,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    output logic [21:0]           sdram_addr,
    input  logic [31:0]           data_read,
    output logic                  refresh_en,
    output logic                  ready
);
    localparam int GW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam int TW = AW - 1;
    localparam int CW = $clog2(READY_DLY + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [21:0]      addr_q, addr_d;
    logic [GW-1:0]    g_q, g_d, ptr_q, ptr_d, grant;
    logic [TW-1:0]    ltag_q, ltag_d;
    logic [31:0]      data_q [SLOTS];
    logic [TW-1:0]    ctag_q [SLOTS];
    logic [SLOTS-1:0] valid_q;
    logic [TW-1:0]    tag_w [SLOTS];
    logic [21:0]      waddr_w [SLOTS];
    logic [SLOTS-1:0] hit, pend;
    logic             any_pend, fill;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [AW-1:0] a;
        assign a = slot_addr[i*AW +: AW];
        assign tag_w[i] = DW16[i] ? a[AW-1:1] : {1'b0, a[AW-1:2]};
        assign waddr_w[i] = OFFSETS[i*22 +: 22] + (DW16[i] ? 22'({a[AW-1:1], 1'b0}) : 22'({1'b0, a[AW-1:2], 1'b0}));
        assign hit[i] = slot_cs[i] & valid_q[i] & (ctag_q[i] == tag_w[i]);
        assign slot_dout[i*16 +: 16] = DW16[i] ? (a[0] ? data_q[i][31:16] : data_q[i][15:0])
                                               : {8'd0, data_q[i][{a[1:0], 3'b000} +: 8]};
    end

    assign pend       = slot_cs & ~hit;
    assign any_pend   = |pend;
    assign slot_ok    = hit;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign ready      = ready_q;
    assign refresh_en = (state_q == IDLE && !any_pend) || downloading;

    // Grant the first pending slot, searching upward from ptr in round-robin mode or from 0 otherwise
    always_comb begin
        logic [GW:0] s;
        s = '0;
        grant = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            s = ((RR != 0) ? {1'b0, ptr_q} : '0) + (GW+1)'(k);
            if (s >= (GW+1)'(SLOTS)) s = s - (GW+1)'(SLOTS);
            if (pend[s[GW-1:0]]) grant = s[GW-1:0];
        end
    end

    // Transaction FSM: one outstanding miss, filled into the latched slot with the latched tag
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        g_d     = g_q;
        ltag_d  = ltag_q;
        ptr_d   = ptr_q;
        fill    = 1'b0;
        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else case (state_q)
            IDLE: if (any_pend) begin
                g_d     = grant;
                addr_d  = waddr_w[grant];
                ltag_d  = tag_w[grant];
                req_d   = 1'b1;
                state_d = REQ;
                ptr_d   = (RR != 0) ? (grant == GW'(SLOTS - 1) ? '0 : grant + 1'b1) : ptr_q;
            end
            REQ: if (sdram_ack) begin
                req_d   = 1'b0;
                fill    = data_rdy;
                state_d = data_rdy ? IDLE : WAIT;
            end
            WAIT: if (data_rdy) begin
                fill    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            g_q     <= '0;
            ltag_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            g_q     <= g_d;
            ltag_q  <= ltag_d;
            ptr_q   <= ptr_d;
        end
    end

    // One-word cache per slot; a download invalidates everything every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                data_q[k] <= '0;
                ctag_q[k] <= '0;
            end
        end else if (downloading) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[g_q] <= 1'b1;
            data_q[g_q]  <= data_read;
            ctag_q[g_q]  <= ltag_q;
        end
    end

    // Ready rises READY_DLY cycles after downloading ends and holds until the next download or reset
    always_ff @(posedge clk) begin
        if (rst || downloading) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (!ready_q) begin
            cnt_q   <= cnt_q + 1'b1;
            ready_q <= cnt_q == CW'(READY_DLY - 1);
        end
    end
endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// tb_jtframe_romrq_arb: directed and randomized checks of the ROM request arbiter against a cache/arbiter model
module tb_jtframe_romrq_arb;
    localparam logic [3:0]  DW   = 4'b0101;
    localparam logic [87:0] OFFS = {22'h3FFFF0, 22'h002000, 22'h000800, 22'h001000};

    logic        clk = 1'b0;
    logic        rst, downloading, ack, rdy, ack_f, rdy_f;
    logic [3:0]  cs, cs_f, ok, ok_f;
    logic [71:0] addr, addr_f;
    logic [63:0] dout, dout_f;
    logic [31:0] rd;
    logic        req, req_f, refresh, refresh_f, ready, ready_f;
    logic [21:0] saddr, saddr_f;
    int          checks = 0, errors = 0;
    bit          mv [4];
    int          mtag [4];
    logic [31:0] mdata [4];
    int          mptr;

    always #5 clk = ~clk;

    jtframe_romrq_arb #(.SLOTS(4), .AW(18), .DW16(DW), .RR(1), .OFFSETS(OFFS), .READY_DLY(16)) u_rr (
        .clk(clk), .rst(rst), .slot_cs(cs), .slot_addr(addr), .slot_dout(dout), .slot_ok(ok),
        .downloading(downloading), .sdram_req(req), .sdram_ack(ack), .data_rdy(rdy),
        .sdram_addr(saddr), .data_read(rd), .refresh_en(refresh), .ready(ready)
    );

    jtframe_romrq_arb #(.SLOTS(4), .AW(18), .DW16(DW), .RR(0), .OFFSETS(OFFS), .READY_DLY(16)) u_fp (
        .clk(clk), .rst(rst), .slot_cs(cs_f), .slot_addr(addr_f), .slot_dout(dout_f), .slot_ok(ok_f),
        .downloading(downloading), .sdram_req(req_f), .sdram_ack(ack_f), .data_rdy(rdy_f),
        .sdram_addr(saddr_f), .data_read(rd), .refresh_en(refresh_f), .ready(ready_f)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
        end
    endtask

    function automatic int a_of(input logic [71:0] v, input int s);
        return int'(v[s*18 +: 18]);
    endfunction

    function automatic int tag_of(input int s, input int a);
        return DW[s] ? a / 2 : a / 4;
    endfunction

    function automatic logic [21:0] exp_addr(input int s, input int a);
        longint w;
        w = longint'(OFFS[s*22 +: 22]) + longint'(DW[s] ? (a / 2) * 2 : (a / 4) * 2);
        return 22'(w % 4194304);
    endfunction

    function automatic bit mhit(input int s);
        return cs[s] && mv[s] && mtag[s] == tag_of(s, a_of(addr, s));
    endfunction

    function automatic logic [3:0] exp_ok();
        logic [3:0] e;
        for (int s = 0; s < 4; s++) e[s] = mhit(s);
        return e;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (mptr + k) % 4;
            if (cs[j] && !mhit(j)) return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_dout(input int s);
        int a;
        a = a_of(addr, s);
        return DW[s] ? 16'(mdata[s] >> (16 * (a % 2))) : 16'((mdata[s] >> (8 * (a % 4))) & 32'hFF);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) mv[s] = 1'b0;
        mptr = 0;
    endtask

    task automatic model_fill(input int g, input int t, input logic [31:0] d);
        mv[g] = 1'b1;
        mtag[g] = t;
        mdata[g] = d;
    endtask

    task automatic check_outputs(input string name);
        logic [3:0] e;
        e = exp_ok();
        chk({name, "_ok"}, ok, e);
        for (int s = 0; s < 4; s++) if (e[s]) chk({name, "_dout"}, dout[s*16 +: 16], exp_dout(s));
    endtask

    task automatic wait_req(output int g, output int t, output logic [21:0] ea);
        int n;
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", req, 1'b1);
        g = model_grant();
        if (g < 0) g = 0;
        mptr = (g + 1) % 4;
        t = tag_of(g, a_of(addr, g));
        ea = exp_addr(g, a_of(addr, g));
        chk("sdram_addr", saddr, ea);
    endtask

    task automatic serve(input logic [31:0] d, output int g);
        int t;
        logic [21:0] ea;
        bit same;
        wait_req(g, t, ea);
        same = ($urandom % 4) == 0;
        ack = 1'b1;
        if (same) begin
            rdy = 1'b1;
            rd = d;
        end
        @(negedge clk);
        ack = 1'b0;
        rdy = 1'b0;
        chk("req_drop", req, 1'b0);
        if (!same) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("addr_stable", saddr, ea);
            rdy = 1'b1;
            rd = d;
            @(negedge clk);
            rdy = 1'b0;
        end
        model_fill(g, t, d);
        check_outputs("fill");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int g, t, n;
        logic [21:0] ea;
        logic [31:0] d;
        logic [21:0] rr_exp [4];
        rr_exp = '{22'h001100, 22'h000880, 22'h002040, 22'h000000};
        rst = 1'b1; cs = '0; addr = '0; cs_f = '0; addr_f = '0; downloading = 1'b0;
        ack = 1'b0; rdy = 1'b0; ack_f = 1'b0; rdy_f = 1'b0; rd = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", req, 1'b0);
        chk("rst_saddr", saddr, 22'h0);
        chk("rst_ok", ok, 4'h0);
        chk("rst_dout", dout, 64'h0);
        chk("rst_refresh", refresh, 1'b1);
        chk("rst_ready", ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        cs = 4'b0001;
        addr[17:0] = 18'h5;
        #1;
        chk("tp1_miss", ok[0], 1'b0);
        chk("tp1_refresh", refresh, 1'b0);
        serve(32'hBEEF1234, g);
        chk("tp1_saddr", saddr, 22'h1004);
        chk("tp1_dout_hi", dout[15:0], 16'hBEEF);
        addr[17:0] = 18'h4;
        #1;
        chk("tp1_hit", ok[0], 1'b1);
        chk("tp1_dout_lo", dout[15:0], 16'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tp1_noreq", req, 1'b0);
        end
        cs = 4'b0011;
        addr[35:18] = 18'h7;
        serve(32'h44332211, g);
        chk("tp2_saddr", saddr, 22'h802);
        chk("tp2_dout_b3", dout[31:16], 16'h0044);
        addr[35:18] = 18'h4;
        #1;
        chk("tp2_hit", ok[1], 1'b1);
        chk("tp2_dout_b0", dout[31:16], 16'h0011);
        @(negedge clk);
        rst = 1'b1;
        cs = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        addr = {18'h20, 18'h40, 18'h100, 18'h100};
        cs = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve($urandom, g);
            chk("rr_order", saddr, rr_exp[k]);
        end
        addr[17:0] = 18'h200;
        addr[53:36] = 18'h80;
        serve($urandom, g);
        chk("rr_again0", saddr, 22'h1200);
        serve($urandom, g);
        chk("rr_again2", saddr, 22'h2080);
        cs = '0;
        cs_f = 4'b1001;
        for (int r = 0; r < 3; r++) begin
            addr_f[17:0] = 18'(r * 8 + 2);
            addr_f[71:54] = 18'(r * 16 + 1);
            for (int st = 0; st < 2; st++) begin
                n = 0;
                while (!req_f && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("fp_req", req_f, 1'b1);
                chk("fp_addr", saddr_f, exp_addr(st == 0 ? 0 : 3, a_of(addr_f, st == 0 ? 0 : 3)));
                ack_f = 1'b1;
                @(negedge clk);
                ack_f = 1'b0;
                rdy_f = 1'b1;
                rd = $urandom;
                @(negedge clk);
                rdy_f = 1'b0;
            end
            chk("fp_ok", ok_f, 4'b1001);
        end
        cs_f = '0;
        repeat (20) @(negedge clk);
        chk("ready_pre", ready, 1'b1);
        cs = 4'b0001;
        addr[17:0] = 18'h30;
        wait_req(g, t, ea);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        downloading = 1'b1;
        @(negedge clk);
        rdy = 1'b1;
        rd = $urandom;
        chk("dl_req", req, 1'b0);
        chk("dl_ok", ok, 4'h0);
        chk("dl_refresh", refresh, 1'b1);
        chk("dl_ready", ready, 1'b0);
        @(negedge clk);
        rdy = 1'b0;
        downloading = 1'b0;
        for (int s = 0; s < 4; s++) mv[s] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) chk("ready_low", ready, 1'b0);
            else chk("ready_rise", ready, 1'b1);
        end
        chk("dl_nofill", ok, exp_ok());
        serve($urandom, g);
        chk("dl_resend", saddr, 22'h1030);
        addr[17:0] = 18'h40;
        wait_req(g, t, ea);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        addr[17:0] = 18'h50;
        @(negedge clk);
        d = $urandom;
        rdy = 1'b1;
        rd = d;
        @(negedge clk);
        rdy = 1'b0;
        model_fill(g, t, d);
        chk("retag_ok", ok[0], 1'b0);
        check_outputs("retag");
        serve($urandom, g);
        chk("retag_saddr", saddr, 22'h1050);
        addr[17:0] = 18'h60;
        wait_req(g, t, ea);
        rst = 1'b1;
        cs = '0;
        @(negedge clk);
        chk("rstq_req", req, 1'b0);
        chk("rstq_refresh", refresh, 1'b1);
        chk("rstq_ok", ok, 4'h0);
        chk("rstq_saddr", saddr, 22'h0);
        rst = 1'b0;
        model_reset();
        ack = 1'b1;
        rdy = 1'b1;
        rd = $urandom;
        @(negedge clk);
        ack = 1'b0;
        rdy = 1'b0;
        cs = 4'b0001;
        #1;
        chk("rstq_nowrite", ok, 4'h0);
        serve($urandom, g);
        cs = '0;
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            cs = 4'($urandom);
            for (int s = 0; s < 4; s++) addr[s*18 +: 18] = 18'($urandom_range(0, 15));
            #1;
            check_outputs("rnd");
            chk("rnd_refresh", refresh, model_grant() < 0);
            n = 0;
            while (model_grant() >= 0 && n < 8) begin
                serve($urandom, g);
                n++;
            end
            cs = '0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
